// File: rtl/seq10010_pkg.sv
// Shared types for the 10010 serial detector: Mealy/Moore state encodings and the fixed pattern.
// Optional SEQ10010_DIFF_EN build macro is consumed by the interface and top, not here.
package seq10010_pkg;

   typedef enum logic [2:0] {
      M0 = 3'd0,
      M1 = 3'd1,
      M2 = 3'd2,
      M3 = 3'd3,
      M4 = 3'd4
   } mealy_state_t;

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4,
      S5 = 3'd5
   } moore_state_t;

   localparam logic [4:0] PATTERN = 5'b10010;

endpackage

// File: rtl/seq_10010_detector_if.sv
// Serial input and detect flags of the 10010 detector; diff exists only with SEQ10010_DIFF_EN.
// master drives the serial bit, slave (the detector) returns the flags.
interface seq_10010_detector_if;

   logic j;
   logic mealy_w;
   logic moore_w;
`ifdef SEQ10010_DIFF_EN
   logic diff;

   modport master (output j, input mealy_w, input moore_w, input diff);
   modport slave  (input j, output mealy_w, output moore_w, output diff);
`else
   modport master (output j, input mealy_w, input moore_w);
   modport slave  (input j, output mealy_w, output moore_w);
`endif

endinterface

// File: rtl/seq10010_moore_fsm.sv
// Moore recogniser for 10010 with overlap; moore_w decoded from state only.
// Flag is high for the full cycle after the edge that samples the final 0.
module seq10010_moore_fsm
   import seq10010_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   output logic moore_w
);

   moore_state_t state_q;
   moore_state_t state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S0;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = S0;
      moore_w = 1'b0;
      case (state_q)
         S0: state_d = j ? S1 : S0;
         S1: state_d = j ? S1 : S2;
         S2: state_d = j ? S1 : S3;
         S3: state_d = j ? S4 : S0;
         S4: state_d = j ? S1 : S5;
         S5: begin
            moore_w = 1'b1;
            // "100100" ends in "100", so a further 0 resumes at S3
            state_d = j ? S1 : S3;
         end
         default: state_d = S0;
      endcase
   end

endmodule

// File: rtl/seq_10010_detector.sv
// 10010 detector running Mealy and Moore FSMs side by side; optional diff via SEQ10010_DIFF_EN.
// mealy_w is combinational from state and j; moore_w lags it by one clock for stable j.
module seq_10010_detector
   import seq10010_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   seq_10010_detector_if.slave      bus
);

   mealy_state_t state_q;
   mealy_state_t state_d;
   logic         mealy_w;
   logic         moore_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= M0;
      else     state_q <= state_d;
   end

   // Advance when j matches the next pattern bit, otherwise fall back to the longest suffix
   always_comb begin
      state_d = M0;
      mealy_w = 1'b0;
      case (state_q)
         M0: state_d = (bus.j == PATTERN[4]) ? M1 : M0;
         M1: state_d = (bus.j == PATTERN[3]) ? M2 : M1;
         M2: state_d = (bus.j == PATTERN[2]) ? M3 : M1;
         M3: state_d = (bus.j == PATTERN[1]) ? M4 : M0;
         M4: begin
            mealy_w = (bus.j == PATTERN[0]);
            state_d = (bus.j == PATTERN[0]) ? M2 : M1;
         end
         default: state_d = M0;
      endcase
   end

   seq10010_moore_fsm u_moore (
      .clk     (clk),
      .rst     (rst),
      .j       (bus.j),
      .moore_w (moore_w)
   );

   assign bus.mealy_w = mealy_w;
   assign bus.moore_w = moore_w;

`ifdef SEQ10010_DIFF_EN
   assign bus.diff = mealy_w ^ moore_w;
`endif

endmodule

// File: tb/tb_seq_10010_detector.sv
// Directed-vector bench: stimulus pushes expected flags, a negedge monitor pops and compares.
module tb_seq_10010_detector;

   logic clk;
   logic rst;
   logic chk_vld;
   int   n_checks;
   int   n_fails;

   seq_10010_detector_if bus ();

   seq_10010_detector dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic  mealy;
      logic  moore;
      string name;
   } exp_t;

   typedef struct {
      int          len;
      logic [15:0] jv;
      logic [15:0] mv;
      logic [15:0] ov;
      string       name;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[5];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: flags are sampled on the falling edge, mid-cycle
   always @(negedge clk) begin
      if (chk_vld) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_empty: monitor sampled with no expected entry");
         end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.mealy_w !== e.mealy) begin
               n_fails++;
               $display("FAIL %s mealy_w: got %b expected %b at %0t", e.name, bus.mealy_w, e.mealy, $time);
            end
            n_checks++;
            if (bus.moore_w !== e.moore) begin
               n_fails++;
               $display("FAIL %s moore_w: got %b expected %b at %0t", e.name, bus.moore_w, e.moore, $time);
            end
`ifdef SEQ10010_DIFF_EN
            n_checks++;
            if (bus.diff !== (e.mealy ^ e.moore)) begin
               n_fails++;
               $display("FAIL %s diff: got %b expected %b at %0t", e.name, bus.diff, e.mealy ^ e.moore, $time);
            end
`endif
         end
      end
   end

   // One bit cycle: drive inputs just after the rising edge and queue the expected flags
   task automatic step(input logic r, input logic jb, input logic em, input logic eo, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst   = r;
      bus.j = jb;
      e.mealy = em;
      e.moore = eo;
      e.name  = nm;
      exp_q.push_back(e);
      chk_vld = 1'b1;
   endtask

   task automatic reset_pulse();
      step(1'b1, 1'b0, 1'b0, 1'b0, "reset_j0");
      step(1'b1, 1'b1, 1'b0, 1'b0, "reset_j1");
   endtask

   initial begin
      exp_t e;
      n_checks = 0;
      n_fails  = 0;
      chk_vld  = 1'b0;
      rst      = 1'b1;
      bus.j    = 1'b0;

      // Strings read left to right in bit-cycle order; flags are the values seen during that cycle
      vecs[0] = '{6,  16'b100100,         16'b000010,         16'b000001,         "basic"};
      vecs[1] = '{9,  16'b100100100,      16'b000010010,      16'b000001001,      "overlap"};
      vecs[2] = '{9,  16'b100110000,      16'b000000000,      16'b000000000,      "near_miss_a"};
      vecs[3] = '{6,  16'b110100,         16'b000000,         16'b000000,         "near_miss_b"};
      vecs[4] = '{14, 16'b00000000100100, 16'b00000000000010, 16'b00000000000001, "long_zero"};

      for (int v = 0; v < 5; v++) begin
         reset_pulse();
         for (int i = 0; i < vecs[v].len; i++) begin
            int b;
            b = vecs[v].len - 1 - i;
            step(1'b0, vecs[v].jv[b], vecs[v].mv[b], vecs[v].ov[b], vecs[v].name);
         end
      end

      // Reset mid-sequence: reach "1001", then reset between edges and present the final 0
      reset_pulse();
      step(1'b0, 1'b1, 1'b0, 1'b0, "rst_mid_pre");
      step(1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_pre");
      step(1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_pre");
      step(1'b0, 1'b1, 1'b0, 1'b0, "rst_mid_pre");
      @(posedge clk);
      #2;
      rst   = 1'b1;
      #1;
      bus.j = 1'b0;
      e.mealy = 1'b0;
      e.moore = 1'b0;
      e.name  = "rst_mid_async";
      exp_q.push_back(e);
      chk_vld = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0, "rst_mid_hold");
      step(1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_post");
      step(1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_post");
      step(1'b0, 1'b1, 1'b0, 1'b0, "rst_mid_post");
      step(1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_post");
      step(1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_post");

      @(posedge clk);
      #1;
      chk_vld = 1'b0;
      repeat (2) @(posedge clk);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
